// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants and the field-bundle type used by the encoder and decoder.
package inst_encoder_pkg;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef struct packed {
        logic [5:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_bundle_t;

    function automatic logic fmt_is_onehot(input logic [5:0] f);
        return (f != 6'd0) && ((f & (f - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port of the encoder.
interface inst_encoder_if;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_format;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic        i_funct7b5;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [31:0] i_imm;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_addr;
    logic        o_err;

    modport slave (
        input  i_valid, i_format, i_opcode, i_funct3, i_funct7b5,
               i_rd, i_rs1, i_rs2, i_imm, i_inst_ready,
        output o_ready, o_inst_valid, o_inst, o_addr, o_err
    );

    modport master (
        output i_valid, i_format, i_opcode, i_funct3, i_funct7b5,
               i_rd, i_rs1, i_rs2, i_imm, i_inst_ready,
        input  o_ready, o_inst_valid, o_inst, o_addr, o_err
    );
endinterface

// File: rtl/inst_encoder_fifo.sv
// Small power-of-two FIFO holding encoded words until the instruction memory accepts them.
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    // Zero when empty so the write port shows 0 during and right after reset.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I field bundles into instruction words and streams them with sequential byte addresses.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    inst_encoder_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    enc_bundle_t      bnd;
    logic [31:0]      inst_enc;
    logic             in_hs, out_hs, push;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;

    assign bnd = {bus.i_format, bus.i_opcode, bus.i_funct3, bus.i_funct7b5,
                  bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_imm};

    always_comb begin
        inst_enc = 32'd0;
        case (1'b1)
            bnd.fmt[FMT_R]: inst_enc = {(bnd.funct7b5 ? 7'b0100000 : 7'b0000000), bnd.rs2, bnd.rs1,
                                        bnd.funct3, bnd.rd, bnd.opcode};
            bnd.fmt[FMT_I]: begin
                inst_enc = {bnd.imm[11:0], bnd.rs1, bnd.funct3, bnd.rd, bnd.opcode};
                // Immediate shifts carry shamt in [24:20] and the arithmetic flag in bit 30.
                if (bnd.opcode == OPC_OP_IMM && (bnd.funct3 == F3_SLL || bnd.funct3 == F3_SRX))
                    inst_enc[31:20] = {1'b0, bnd.funct7b5, 5'b00000, bnd.imm[4:0]};
            end
            bnd.fmt[FMT_S]: inst_enc = {bnd.imm[11:5], bnd.rs2, bnd.rs1, bnd.funct3,
                                        bnd.imm[4:0], bnd.opcode};
            bnd.fmt[FMT_B]: inst_enc = {bnd.imm[12], bnd.imm[10:5], bnd.rs2, bnd.rs1, bnd.funct3,
                                        bnd.imm[4:1], bnd.imm[11], bnd.opcode};
            bnd.fmt[FMT_U]: inst_enc = {bnd.imm[31:12], bnd.rd, bnd.opcode};
            bnd.fmt[FMT_J]: inst_enc = {bnd.imm[20], bnd.imm[10:1], bnd.imm[11], bnd.imm[19:12],
                                        bnd.rd, bnd.opcode};
            default:        inst_enc = 32'd0;
        endcase
    end

    assign bus.o_ready      = ~i_rst & (fifo_count < CNT_W'(DEPTH));
    assign in_hs            = bus.i_valid & bus.o_ready;
    assign push             = in_hs & ~fifo_full & fmt_is_onehot(bnd.fmt);
    assign bus.o_inst_valid = ~fifo_empty;
    assign out_hs           = bus.o_inst_valid & bus.i_inst_ready;
    assign bus.o_addr       = addr_q;
    assign bus.o_err        = err_q;

    enc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .wdata (inst_enc),
        .pop   (out_hs),
        .rdata (bus.o_inst),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        addr_d = out_hs ? addr_q + 32'd4 : addr_q;
        err_d  = err_q | (in_hs & ~fmt_is_onehot(bnd.fmt));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed RV32I encodings, backpressure, bad formats, reset, random traffic.
module tb_inst_encoder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 2;

    typedef struct {
        logic [5:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_addr;
    logic        m_err;

    always #5 clk = ~clk;

    inst_encoder_if bus();

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference encoding written as field shifts straight from the ISA bit layouts.
    function automatic logic [31:0] ref_encode(input vec_t v);
        logic [31:0] w, op, rd, rs1, rs2, f3, imm;
        op = 32'(v.op); rd = 32'(v.rd); rs1 = 32'(v.rs1); rs2 = 32'(v.rs2);
        f3 = 32'(v.f3); imm = v.imm;
        w = 32'd0;
        if (v.fmt == 6'b000001)
            w = (v.f7 ? 32'h4000_0000 : 32'd0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        else if (v.fmt == 6'b000010) begin
            w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            if (v.op == 7'b0010011 && (v.f3 == 3'd1 || v.f3 == 3'd5))
                w = (w & 32'h000F_FFFF) | ((imm & 32'd31) << 20) | (v.f7 ? 32'h4000_0000 : 32'd0);
        end else if (v.fmt == 6'b000100)
            w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((imm & 32'd31) << 7) | op;
        else if (v.fmt == 6'b001000)
            w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (rs2 << 20) | (rs1 << 15)
              | (f3 << 12) | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | op;
        else if (v.fmt == 6'b010000)
            w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        else if (v.fmt == 6'b100000)
            w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) | (((imm >> 11) & 32'd1) << 20)
              | (((imm >> 12) & 32'd255) << 12) | (rd << 7) | op;
        return w;
    endfunction

    task automatic drive(input vec_t v);
        bus.i_valid = 1'b1; bus.i_format = v.fmt; bus.i_opcode = v.op; bus.i_funct3 = v.f3;
        bus.i_funct7b5 = v.f7; bus.i_rd = v.rd; bus.i_rs1 = v.rs1; bus.i_rs2 = v.rs2; bus.i_imm = v.imm;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    task automatic rand_bundle(output vec_t v);
        v.fmt = 6'(1 << $urandom_range(0, 5));
        v.op  = ($urandom_range(0, 3) == 0) ? 7'b0010011 : 7'($urandom);
        v.f3  = 3'($urandom); v.f7 = 1'($urandom);
        v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.imm = $urandom; v.exp = 32'd0;
    endtask

    task automatic model_reset();
        exp_q.delete(); m_addr = BASE; m_err = 1'b0;
    endtask

    // Advance one clock, updating the model from the handshakes the bench is presenting.
    task automatic tick();
        bit in_hs, out_hs;
        vec_t v;
        in_hs  = bus.i_valid && (exp_q.size() < DEPTH);
        out_hs = (exp_q.size() > 0) && bus.i_inst_ready;
        if (out_hs) begin void'(exp_q.pop_front()); m_addr = m_addr + 32'd4; end
        if (in_hs) begin
            v.fmt = bus.i_format; v.op = bus.i_opcode; v.f3 = bus.i_funct3; v.f7 = bus.i_funct7b5;
            v.rd = bus.i_rd; v.rs1 = bus.i_rs1; v.rs2 = bus.i_rs2; v.imm = bus.i_imm; v.exp = 32'd0;
            if ($countones(v.fmt) == 1) exp_q.push_back(ref_encode(v));
            else m_err = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); bus.i_inst_ready = 1'b0; bus.i_format = 6'd1;
        bus.i_opcode = 7'd0; bus.i_funct3 = 3'd0; bus.i_funct7b5 = 1'b0;
        bus.i_rd = 5'd0; bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd0; bus.i_imm = 32'd0;
        model_reset();
        @(negedge clk); @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", bus.o_ready); end
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.o_inst_valid); end
        n_vec++; if (bus.o_inst !== 32'd0) begin n_err++; $display("FAIL reset_inst: got %h want 0", bus.o_inst); end
        n_vec++; if (bus.o_addr !== BASE) begin n_err++; $display("FAIL reset_addr: got %h want %h", bus.o_addr, BASE); end
        n_vec++; if (bus.o_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", bus.o_err); end
        rst = 1'b0; #1;
        n_vec++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b want 1", bus.o_ready); end
    endtask

    task automatic test_directed();
        vec_t dirs[8];
        dirs[0] = '{fmt:6'b000010, op:7'b0010011, f3:3'b000, f7:1'b0, rd:5'd1, rs1:5'd0, rs2:5'd0, imm:32'd5,  exp:32'h00500093};
        dirs[1] = '{fmt:6'b000001, op:7'b0110011, f3:3'b000, f7:1'b1, rd:5'd3, rs1:5'd1, rs2:5'd2, imm:32'd0,  exp:32'h402081B3};
        dirs[2] = '{fmt:6'b000100, op:7'b0100011, f3:3'b010, f7:1'b0, rd:5'd0, rs1:5'd1, rs2:5'd2, imm:32'd8,  exp:32'h0020A423};
        dirs[3] = '{fmt:6'b001000, op:7'b1100011, f3:3'b000, f7:1'b0, rd:5'd0, rs1:5'd1, rs2:5'd2, imm:32'd16, exp:32'h00208863};
        dirs[4] = '{fmt:6'b100000, op:7'b1101111, f3:3'b000, f7:1'b0, rd:5'd1, rs1:5'd0, rs2:5'd0, imm:32'd8,  exp:32'h008000EF};
        dirs[5] = '{fmt:6'b010000, op:7'b0110111, f3:3'b000, f7:1'b0, rd:5'd5, rs1:5'd0, rs2:5'd0, imm:32'h12345000, exp:32'h123452B7};
        dirs[6] = '{fmt:6'b000010, op:7'b0010011, f3:3'b101, f7:1'b1, rd:5'd1, rs1:5'd1, rs2:5'd0, imm:32'd3,  exp:32'h4030D093};
        dirs[7] = '{fmt:6'b000010, op:7'b0010011, f3:3'b001, f7:1'b0, rd:5'd1, rs1:5'd1, rs2:5'd0, imm:32'd3,  exp:32'h00309093};
        bus.i_inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(dirs[i]);
            n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_pre_valid: got %0b want 0", i, bus.o_inst_valid); end
            tick(); idle();
            n_vec++; if (bus.o_inst_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid: got %0b want 1", i, bus.o_inst_valid); end
            n_vec++; if (bus.o_inst !== dirs[i].exp) begin n_err++; $display("FAIL dir%0d_inst: got %h want %h", i, bus.o_inst, dirs[i].exp); end
            n_vec++; if (bus.o_addr !== BASE + 32'(4 * i)) begin n_err++; $display("FAIL dir%0d_addr: got %h want %h", i, bus.o_addr, BASE + 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        vec_t b[3];
        logic [31:0] w[3];
        logic [31:0] a0;
        bus.i_inst_ready = 1'b0; a0 = m_addr;
        for (int i = 0; i < 3; i++) begin rand_bundle(b[i]); w[i] = ref_encode(b[i]); end
        drive(b[0]);
        n_vec++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %0b want 1", bus.o_ready); end
        tick(); drive(b[1]);
        n_vec++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %0b want 1", bus.o_ready); end
        tick(); drive(b[2]);
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %0b want 0", bus.o_ready); end
            n_vec++; if (bus.o_inst !== w[0]) begin n_err++; $display("FAIL b2b_hold_inst: got %h want %h", bus.o_inst, w[0]); end
            n_vec++; if (bus.o_addr !== a0) begin n_err++; $display("FAIL b2b_hold_addr: got %h want %h", bus.o_addr, a0); end
            tick();
        end
        bus.i_inst_ready = 1'b1;
        n_vec++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_pop_ready: got %0b want 0", bus.o_ready); end
        tick();
        n_vec++; if (bus.o_inst !== w[1]) begin n_err++; $display("FAIL b2b_word1: got %h want %h", bus.o_inst, w[1]); end
        n_vec++; if (bus.o_addr !== a0 + 32'd4) begin n_err++; $display("FAIL b2b_addr1: got %h want %h", bus.o_addr, a0 + 32'd4); end
        n_vec++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after: got %0b want 1", bus.o_ready); end
        tick(); idle();
        n_vec++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== w[2]) begin n_err++; $display("FAIL b2b_word2: got %h want %h", bus.o_inst, w[2]); end
        n_vec++; if (bus.o_addr !== a0 + 32'd8) begin n_err++; $display("FAIL b2b_addr2: got %h want %h", bus.o_addr, a0 + 32'd8); end
        tick();
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b want 0", bus.o_inst_valid); end
    endtask

    task automatic test_bad_format();
        vec_t v;
        logic [31:0] a0;
        bus.i_inst_ready = 1'b1; a0 = m_addr;
        rand_bundle(v); v.fmt = 6'b000011; drive(v);
        tick(); idle();
        n_vec++; if (bus.o_err !== 1'b1) begin n_err++; $display("FAIL bad_err: got %0b want 1", bus.o_err); end
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL bad_valid: got %0b want 0", bus.o_inst_valid); end
        rand_bundle(v); v.fmt = 6'b000000; drive(v);
        tick(); rand_bundle(v); drive(v);
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL bad_zero_valid: got %0b want 0", bus.o_inst_valid); end
        tick(); idle();
        n_vec++; if (bus.o_inst !== ref_encode(v)) begin n_err++; $display("FAIL bad_next_inst: got %h want %h", bus.o_inst, ref_encode(v)); end
        n_vec++; if (bus.o_addr !== a0) begin n_err++; $display("FAIL bad_next_addr: got %h want %h", bus.o_addr, a0); end
        n_vec++; if (bus.o_err !== 1'b1) begin n_err++; $display("FAIL bad_sticky: got %0b want 1", bus.o_err); end
        tick();
    endtask

    task automatic test_random();
        vec_t v;
        for (int c = 0; c < 400; c++) begin
            n_vec++; if (bus.o_ready !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready c%0d: got %0b", c, bus.o_ready); end
            n_vec++; if (bus.o_inst_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %0b", c, bus.o_inst_valid); end
            n_vec++; if (bus.o_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.o_addr, m_addr); end
            n_vec++; if (bus.o_err !== m_err) begin n_err++; $display("FAIL rnd_err c%0d: got %0b want %0b", c, bus.o_err, m_err); end
            if (exp_q.size() > 0) begin
                n_vec++; if (bus.o_inst !== exp_q[0]) begin n_err++; $display("FAIL rnd_inst c%0d: got %h want %h", c, bus.o_inst, exp_q[0]); end
            end
            rand_bundle(v);
            if ($urandom_range(0, 19) == 0) v.fmt = 6'($urandom);
            drive(v);
            bus.i_valid      = ($urandom_range(0, 9) < 6);
            bus.i_inst_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        vec_t v;
        bus.i_inst_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_bundle(v); drive(v); tick(); end
        idle();
        n_vec++; if (bus.o_inst_valid !== 1'b1 || bus.o_ready !== 1'b0) begin n_err++; $display("FAIL mid_prefill: valid %0b ready %0b want 1 0", bus.o_inst_valid, bus.o_ready); end
        rst = 1'b1; #1;
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b want 0", bus.o_inst_valid); end
        n_vec++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %0b want 0", bus.o_ready); end
        n_vec++; if (bus.o_addr !== BASE) begin n_err++; $display("FAIL mid_addr: got %h want %h", bus.o_addr, BASE); end
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        n_vec++; if (bus.o_ready !== 1'b1 || bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_release: ready %0b valid %0b want 1 0", bus.o_ready, bus.o_inst_valid); end
        n_vec++; if (bus.o_err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %0b want 0", bus.o_err); end
        rand_bundle(v); drive(v); bus.i_inst_ready = 1'b1;
        tick(); idle();
        n_vec++; if (bus.o_inst !== ref_encode(v)) begin n_err++; $display("FAIL mid_first_inst: got %h want %h", bus.o_inst, ref_encode(v)); end
        n_vec++; if (bus.o_addr !== BASE) begin n_err++; $display("FAIL mid_first_addr: got %h want %h", bus.o_addr, BASE); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_bad_format();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, address assigned to the first emitted instruction after reset.
REQ-002 Parameter DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  field bundle valid.
REQ-006 o_ready  output  1  encoder can accept a bundle (buffer not full).
REQ-007 i_format  input  6  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J.
REQ-008 i_opcode  input  7  opcode, placed verbatim in inst[6:0].
REQ-009 i_funct3  input  3  funct3, inst[14:12] (R/I/S/B only).
REQ-010 i_funct7b5  input  1  inst[30] for R-type and I-type shifts.
REQ-011 i_rd, i_rs1, i_rs2  input  5 each  register indices.
REQ-012 i_imm  input  32  sign-extended immediate, byte offset (U: upper 20 bits used).
REQ-013 o_inst_valid  output  1  o_inst/o_addr valid for instruction-memory write.
REQ-014 i_inst_ready  input  1  sink accepts o_inst this cycle.
REQ-015 o_inst  output  32  encoded RV32I word.
REQ-016 o_addr  output  32  byte address of o_inst.
REQ-017 o_err  output  1  sticky: a bundle with non-one-hot i_format was received.

Function
REQ-018 Input handshake = i_valid & o_ready; output handshake = o_inst_valid & i_inst_ready.
REQ-019 o_ready SHALL equal (buffer count < DEPTH); an output pop in the same cycle does not raise o_ready combinationally.
REQ-020 R: {funct7b5? 7'b0100000 : 7'b0, rs2, rs1, funct3, rd, opcode}.
REQ-021 I: {imm[11:0], rs1, funct3, rd, opcode}; if opcode 0010011 and funct3 in {001,101}, inst[31:25] = {1'b0, funct7b5, 5'b0} and inst[24:20] = imm[4:0].
REQ-022 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; imm[0] ignored.
REQ-024 U: {imm[31:12], rd, opcode}.
REQ-025 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; imm[0] ignored.
REQ-026 Encoding is combinational into the buffer write; an accepted bundle appears on o_inst with o_inst_valid=1 on the next cycle when buffer was empty (latency 1).
REQ-027 Buffer is FIFO ordered; o_inst/o_addr SHALL hold stable while o_inst_valid=1 and i_inst_ready=0.
REQ-028 Simultaneous push and pop when not full: both occur, count unchanged.
REQ-029 Address counter starts at BASE_ADDR, increments by 4 on each output handshake, wraps modulo 2^32; o_addr = counter.
REQ-030 Non-one-hot i_format (zero or multiple bits) on an input handshake: bundle dropped, no buffer write, counter unchanged, o_err set next cycle and held until reset.

Reset
REQ-031 While i_rst=1: o_ready=0, o_inst_valid=0, o_inst=0, o_addr=BASE_ADDR, o_err=0, buffer empty.
REQ-032 Reset asserted mid-operation discards all buffered words immediately; o_ready=1 in the first cycle after i_rst deasserts.

Structure
REQ-033 Shared package holds format one-hot bit indices, RV32I opcode constants (OP, OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL) and shift funct3 codes, shared with the decoder.
REQ-034 One sub-module, enc_fifo (DEPTH x 32, count, full/empty), instantiated once; format packing stays in inst_encoder.

Verification
REQ-035 addi x1,x0,5 (I, opcode 0010011, imm 5) -> o_inst 0x00500093 at o_addr 0x0 one cycle later; sub x3,x1,x2 -> 0x402081B3 at 0x4.
REQ-036 sw x2,8(x1) -> 0x0020A423; beq x1,x2,+16 -> 0x00208863; jal x1,+8 -> 0x008000EF; lui x5 imm 0x12345000 -> 0x123452B7.
REQ-037 srai x1,x1,3 (funct7b5=1, funct3 101) -> 0x4030D093; slli x1,x1,3 -> 0x00309093.
REQ-038 i_inst_ready=0, push 3 bundles back-to-back -> 2 accepted, o_ready=0 after second, o_inst stable; release -> words in order at 0x0, 0x4, then third at 0x8.
REQ-039 i_format=6'b000011 -> o_err=1 next cycle, no o_inst_valid, next valid bundle still gets the expected address.
REQ-040 Assert i_rst with 2 buffered words -> o_inst_valid=0 immediately; after release first new word at BASE_ADDR.
